// File: rtl/cv32e41p_alu_mul_serial_if.sv
// Operand/result handshake bundle for the serial multiplier.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface cv32e41p_alu_mul_serial_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH-1:0] OpA_DI;
  logic [C_WIDTH-1:0] OpB_DI;
  logic [1:0]         OpCode_SI;
  logic               InVld_SI;
  logic               InRdy_SO;
  logic               OutVld_SO;
  logic               OutRdy_SI;
  logic [C_WIDTH-1:0] Res_DO;
  logic [1:0]         State_SO;

  modport slave (
    input  OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
    output InRdy_SO, OutVld_SO, Res_DO, State_SO
  );

  modport master (
    output OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
    input  InRdy_SO, OutVld_SO, Res_DO, State_SO
  );
endinterface

// File: rtl/cv32e41p_alu_mul_serial.sv
// Serial radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied unsigned over C_WIDTH cycles; the sign is reapplied on the full product.
module cv32e41p_alu_mul_serial #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input logic                       Clk_CI,
  input logic                       Rst_RI,
  cv32e41p_alu_mul_serial_if.slave  bus_s
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [C_WIDTH-1:0]     m_q, m_d;
  logic [C_WIDTH-1:0]     q_q, q_d;
  logic [C_WIDTH:0]       acc_q, acc_d;
  logic [C_LOG_WIDTH-1:0] cnt_q, cnt_d;
  logic                   res_inv_q, res_inv_d;
  logic                   hi_sel_q, hi_sel_d;

  logic                   a_sgn, b_sgn;
  logic [C_WIDTH:0]       sum;
  logic [2*C_WIDTH:0]     shifted;
  logic [2*C_WIDTH-1:0]   prod, prod_s;
  logic                   in_rdy, out_vld;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_inv_q <= 1'b0;
      hi_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_inv_q <= res_inv_d;
      hi_sel_q  <= hi_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_inv_d = res_inv_q;
    hi_sel_d  = hi_sel_q;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;

    // MUL takes the unsigned path: its low half does not depend on signedness.
    a_sgn   = ((bus_s.OpCode_SI == 2'd1) || (bus_s.OpCode_SI == 2'd2)) && bus_s.OpA_DI[C_WIDTH-1];
    b_sgn   = (bus_s.OpCode_SI == 2'd1) && bus_s.OpB_DI[C_WIDTH-1];
    sum     = acc_q + (q_q[0] ? {1'b0, m_q} : '0);
    shifted = {sum, q_q} >> 1;

    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus_s.InVld_SI) begin
          m_d       = a_sgn ? -bus_s.OpA_DI : bus_s.OpA_DI;
          q_d       = b_sgn ? -bus_s.OpB_DI : bus_s.OpB_DI;
          acc_d     = '0;
          cnt_d     = C_LOG_WIDTH'(C_WIDTH - 1);
          res_inv_d = a_sgn ^ b_sgn;
          hi_sel_d  = (bus_s.OpCode_SI != 2'd0);
          state_d   = MULT;
        end
      end
      MULT: begin
        acc_d = shifted[2*C_WIDTH:C_WIDTH];
        q_d   = shifted[C_WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: begin
        out_vld = 1'b1;
        if (bus_s.OutRdy_SI) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The carry bit of acc is always 0 once shifting is done, so the low C_WIDTH bits suffice.
  assign prod   = {acc_q[C_WIDTH-1:0], q_q};
  assign prod_s = res_inv_q ? -prod : prod;

  assign bus_s.Res_DO    = hi_sel_q ? prod_s[2*C_WIDTH-1:C_WIDTH] : prod_s[C_WIDTH-1:0];
  assign bus_s.InRdy_SO  = in_rdy;
  assign bus_s.OutVld_SO = out_vld;
  assign bus_s.State_SO  = state_q;

endmodule
